// File: rtl/msg_rr_arbiter_if.sv
// avalon_st_if: one Avalon-ST style message stream.
//   data, empty : payload and count of unused trailing symbols on the eop beat
//   sop, eop    : first / last beat of a message
//   valid       : source has a beat this cycle
//   ready       : sink accepts the beat this cycle (beat moves on valid & ready)
// master modport drives the payload side, slave modport drives ready.
interface avalon_st_if #(
  parameter int DATA_W  = 32,
  parameter int EMPTY_W = 2
);
  logic [DATA_W-1:0]  data;
  logic [EMPTY_W-1:0] empty;
  logic               sop;
  logic               eop;
  logic               valid;
  logic               ready;

  modport master (output data, output empty, output sop, output eop, output valid, input ready);
  modport slave  (input data, input empty, input sop, input eop, input valid, output ready);
endinterface

// File: rtl/msg_rr_arbiter.sv
// msg_rr_arbiter: round-robin arbiter that merges NUM_PORTS message streams onto
// one output stream with whole-message locking.
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   msg_in[]   : requester streams (slave side)
//   msg_out    : shared output stream (master side)
//   port_en    : 1 = port takes part in arbitration, 0 = its messages are drained
//   grant_oh   : one-hot owner of msg_out, zero when idle
//   busy       : a message is locked onto msg_out
//   msg_cnt[]  : saturating count of messages forwarded per port
//   drop_cnt[] : saturating count of messages drained per port
//   proto_err  : one-cycle pulse after any orphan beat was discarded
module msg_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int CNT_W     = 16,
  parameter int DATA_W    = 32,
  parameter int EMPTY_W   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  avalon_st_if.slave           msg_in [NUM_PORTS],
  avalon_st_if.master          msg_out,
  input  logic [NUM_PORTS-1:0] port_en,
  output logic [NUM_PORTS-1:0] grant_oh,
  output logic                 busy,
  output logic [CNT_W-1:0]     msg_cnt  [NUM_PORTS],
  output logic [CNT_W-1:0]     drop_cnt [NUM_PORTS],
  output logic                 proto_err
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [NUM_PORTS-1:0] drain_q, drain_d;
  logic                 perr_q;

  // Flattened copies of the interface array so ports can be indexed at run time.
  logic [NUM_PORTS-1:0] in_valid, in_sop, in_eop, in_ready;
  logic [DATA_W-1:0]    in_data  [NUM_PORTS];
  logic [EMPTY_W-1:0]   in_empty [NUM_PORTS];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign in_valid[p]     = msg_in[p].valid;
    assign in_sop[p]       = msg_in[p].sop;
    assign in_eop[p]       = msg_in[p].eop;
    assign in_data[p]      = msg_in[p].data;
    assign in_empty[p]     = msg_in[p].empty;
    assign msg_in[p].ready = in_ready[p];
  end

  logic [IDX_W-1:0]     owner_idx;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_found;
  logic [NUM_PORTS-1:0] req, start_drain, draining, orphan;
  logic [NUM_PORTS-1:0] drop_evt, fwd_evt;
  logic                 out_acc, out_eop_acc;

  assign busy     = (state_q == LOCKED);
  assign grant_oh = grant_q;

  // Owner index, and the output mux driven from the locked owner only.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    owner_idx = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant_q[p]) owner_idx = IDX_W'(p);
    end
  end

  assign msg_out.valid = busy & in_valid[owner_idx];
  assign msg_out.data  = in_data[owner_idx];
  assign msg_out.empty = in_empty[owner_idx];
  assign msg_out.sop   = in_sop[owner_idx];
  assign msg_out.eop   = in_eop[owner_idx];

  assign out_acc     = msg_out.valid & msg_out.ready;
  assign out_eop_acc = out_acc & in_eop[owner_idx];

  // Per-port classification of the presented beat. port_en only matters on a
  // sop beat: once a port is draining it stays so until its eop is taken.
  always_comb begin
    req         = '0;
    start_drain = '0;
    draining    = '0;
    orphan      = '0;
    in_ready    = '0;
    drop_evt    = '0;
    drain_d     = '0;
    fwd_evt     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      req[p]         = (state_q == IDLE) & in_valid[p] & in_sop[p] & port_en[p] & ~drain_q[p];
      start_drain[p] = ~grant_q[p] & ~drain_q[p] & in_valid[p] & in_sop[p] & ~port_en[p];
      draining[p]    = drain_q[p] | start_drain[p];
      orphan[p]      = ~grant_q[p] & ~draining[p] & in_valid[p] & ~in_sop[p];
      // No handshake completes while reset is held, so an abandoned message's
      // remaining beats are all seen as orphans after release.
      if (grant_q[p]) in_ready[p] = rst_n & busy & msg_out.ready;
      else            in_ready[p] = rst_n & (draining[p] | orphan[p]);
      drop_evt[p]    = draining[p] & in_valid[p] & in_eop[p];
      drain_d[p]     = draining[p] & ~(in_valid[p] & in_eop[p]);
      fwd_evt[p]     = grant_q[p] & out_eop_acc;
    end
  end

  // Rotating-priority search starting just after the last granted port.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      int c;
      c = int'(last_q) + k;
      if (c >= NUM_PORTS) c = c - NUM_PORTS;
      if (!win_found && req[c]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(c);
      end
    end
  end

  // Next-state logic: lock on a win, release on the accepted eop beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          grant_d = NUM_PORTS'(1) << win_idx;
        end
      end
      LOCKED: begin
        if (out_eop_acc) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_idx;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      drain_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      drain_q <= drain_d;
      perr_q  <= |orphan;
    end
  end

  assign proto_err = perr_q;

  // Counters are architectural state read by software, so unlike a data memory
  // every entry is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        msg_cnt[p]  <= '0;
        drop_cnt[p] <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (fwd_evt[p] && (msg_cnt[p] != '1))   msg_cnt[p]  <= msg_cnt[p] + 1'b1;
        if (drop_evt[p] && (drop_cnt[p] != '1)) drop_cnt[p] <= drop_cnt[p] + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_msg_rr_arbiter.sv
// Directed bench for msg_rr_arbiter: queue-fed sources per port, a negedge
// monitor that records every accepted output beat, and hand-computed checks.
module tb_msg_rr_arbiter;

  localparam int NP = 4;
  localparam int CW = 2;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
    logic [1:0]  empty;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NP-1:0] port_en;
  logic          out_ready;
  logic [NP-1:0] src_valid;
  beat_t         src_beat [NP];
  logic [NP-1:0] tb_ready;
  logic [NP-1:0] acc;
  logic [NP-1:0] grant_oh;
  logic          busy;
  logic [CW-1:0] msg_cnt  [NP];
  logic [CW-1:0] drop_cnt [NP];
  logic          proto_err;

  beat_t src_q [NP][$];
  beat_t outq [$];
  int    outcyc [$];
  int    cyc = 0;
  int    perr_cnt = 0;
  int    total = 0;
  int    bad = 0;

  avalon_st_if msg_in_if [NP] ();
  avalon_st_if msg_out_if ();

  for (genvar p = 0; p < NP; p++) begin : g_src
    assign msg_in_if[p].valid = src_valid[p];
    assign msg_in_if[p].sop   = src_beat[p].sop;
    assign msg_in_if[p].eop   = src_beat[p].eop;
    assign msg_in_if[p].data  = src_beat[p].data;
    assign msg_in_if[p].empty = src_beat[p].empty;
    assign tb_ready[p]        = msg_in_if[p].ready;
  end
  assign msg_out_if.ready = out_ready;

  msg_rr_arbiter #(.NUM_PORTS(NP), .CNT_W(CW), .DATA_W(32), .EMPTY_W(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .msg_in    (msg_in_if),
    .msg_out   (msg_out_if),
    .port_en   (port_en),
    .grant_oh  (grant_oh),
    .busy      (busy),
    .msg_cnt   (msg_cnt),
    .drop_cnt  (drop_cnt),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Handshakes are sampled mid-cycle, well away from the edge.
  always @(negedge clk) begin
    for (int p = 0; p < NP; p++) acc[p] = src_valid[p] & tb_ready[p];
    if (msg_out_if.valid && out_ready) begin
      outq.push_back('{sop: msg_out_if.sop, eop: msg_out_if.eop,
                       data: msg_out_if.data, empty: msg_out_if.empty});
      outcyc.push_back(cyc);
    end
    if (proto_err) perr_cnt++;
  end

  task automatic refresh();
    for (int p = 0; p < NP; p++) begin
      src_valid[p] = (src_q[p].size() != 0);
      if (src_q[p].size() != 0) src_beat[p] = src_q[p][0];
      else                      src_beat[p] = '0;
    end
  endtask

  // Sources advance 1 time unit after each edge when their last beat was taken.
  always @(posedge clk) begin
    #1;
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
    end
    refresh();
  end

  function automatic beat_t mk_beat(input int p, input int tag, input int b, input int n);
    beat_t r;
    r.sop   = (b == 0);
    r.eop   = (b == n - 1);
    r.data  = {8'(p), 8'(tag), 16'(b)};
    r.empty = 2'(b);
    return r;
  endfunction

  task automatic push_msg(input int p, input int n, input int tag);
    for (int b = 0; b < n; b++) src_q[p].push_back(mk_beat(p, tag, b, n));
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_out(input int n, input int budget);
    int left;
    left = budget;
    while (outq.size() < n && left > 0) begin
      tick();
      left--;
    end
    check("out_count", 64'(outq.size()), 64'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) src_q[p].delete();
    outq.delete();
    outcyc.delete();
    refresh();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int p0;
    int ord_p [4];
    int ord_t [4];
    beat_t orph;

    port_en   = '1;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    refresh();
    tick();
    tick();

    // Reset state.
    check("rst_grant", 64'(grant_oh), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_out_valid", 64'(msg_out_if.valid), 64'(0));
    check("rst_proto_err", 64'(proto_err), 64'(0));
    for (int p = 0; p < NP; p++) begin
      check("rst_msg_cnt", 64'(msg_cnt[p]), 64'(0));
      check("rst_drop_cnt", 64'(drop_cnt[p]), 64'(0));
    end
    rst_n = 1'b1;
    tick();

    // Four simultaneous 3-beat messages: grants 0,1,2,3, no interleave.
    for (int p = 0; p < NP; p++) push_msg(p, 3, 1);
    refresh();
    t0 = cyc;
    #1;
    check("t1_idle_out_valid", 64'(msg_out_if.valid), 64'(0));
    check("t1_idle_ready0", 64'(tb_ready[0]), 64'(0));
    tick();
    check("t1_grant0", 64'(grant_oh), 64'(4'b0001));
    check("t1_busy", 64'(busy), 64'(1));
    #1;
    check("t1_waiter_ready", 64'(tb_ready[1]), 64'(0));
    wait_out(12, 60);
    for (int i = 0; i < 12 && i < outq.size(); i++)
      check("t1_beat", 64'(outq[i]), 64'(mk_beat(i / 3, 1, i % 3, 3)));
    if (outcyc.size() != 0) check("t1_latency", 64'(outcyc[0] - t0), 64'(1));
    tick();
    for (int p = 0; p < NP; p++) check("t1_msg_cnt", 64'(msg_cnt[p]), 64'(1));
    check("t1_idle_grant", 64'(grant_oh), 64'(0));
    check("t1_idle_busy", 64'(busy), 64'(0));

    // Port 1 back-to-back against waiting port 2: order 1,2,1,2.
    do_reset();
    push_msg(1, 2, 1);
    push_msg(1, 2, 2);
    push_msg(2, 2, 1);
    push_msg(2, 2, 2);
    refresh();
    wait_out(8, 60);
    ord_p = '{1, 2, 1, 2};
    ord_t = '{1, 1, 2, 2};
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 2; b++)
        if (2 * k + b < outq.size())
          check("t2_beat", 64'(outq[2 * k + b]), 64'(mk_beat(ord_p[k], ord_t[k], b, 2)));
    tick();
    check("t2_msg_cnt1", 64'(msg_cnt[1]), 64'(2));
    check("t2_msg_cnt2", 64'(msg_cnt[2]), 64'(2));

    // Disabled port 3 drains a 4-beat message; port_en rises after beat 2.
    do_reset();
    p0 = perr_cnt;
    port_en = 4'b0111;
    push_msg(3, 4, 3);
    refresh();
    #1;
    check("t3_drain_ready_sop", 64'(tb_ready[3]), 64'(1));
    check("t3_out_valid", 64'(msg_out_if.valid), 64'(0));
    tick();
    tick();
    port_en = 4'b1111;
    #1;
    check("t3_drain_ready_mid", 64'(tb_ready[3]), 64'(1));
    check("t3_out_valid_mid", 64'(msg_out_if.valid), 64'(0));
    tick();
    tick();
    tick();
    check("t3_drop_cnt", 64'(drop_cnt[3]), 64'(1));
    check("t3_msg_cnt", 64'(msg_cnt[3]), 64'(0));
    check("t3_out_none", 64'(outq.size()), 64'(0));
    check("t3_src_empty", 64'(src_q[3].size()), 64'(0));
    check("t3_no_proto_err", 64'(perr_cnt - p0), 64'(0));
    check("t3_busy", 64'(busy), 64'(0));

    // Output stall 1,0,0,1 while port 0 owns the output.
    do_reset();
    out_ready = 1'b1;
    push_msg(0, 4, 4);
    refresh();
    tick();
    #1;
    check("t4_mirror", 64'(tb_ready[0]), 64'(1));
    for (int k = 0; k < 3; k++) begin
      tick();
      out_ready = (k == 2);
      #1;
      check("t4_mirror", 64'(tb_ready[0]), 64'(out_ready));
      check("t4_out_valid", 64'(msg_out_if.valid), 64'(1));
    end
    out_ready = 1'b1;
    wait_out(4, 20);
    tick();
    check("t4_no_dup", 64'(outq.size()), 64'(4));
    for (int b = 0; b < 4 && b < outq.size(); b++)
      check("t4_beat", 64'(outq[b]), 64'(mk_beat(0, 4, b, 4)));
    check("t4_msg_cnt", 64'(msg_cnt[0]), 64'(1));

    // Orphan beat on port 2, then two orphans in the same cycle.
    do_reset();
    orph = mk_beat(2, 5, 1, 3);
    src_q[2].push_back(orph);
    refresh();
    #1;
    check("t5_orphan_ready", 64'(tb_ready[2]), 64'(1));
    check("t5_out_valid", 64'(msg_out_if.valid), 64'(0));
    check("t5_perr_before", 64'(proto_err), 64'(0));
    tick();
    check("t5_perr_pulse", 64'(proto_err), 64'(1));
    check("t5_out_valid_after", 64'(msg_out_if.valid), 64'(0));
    check("t5_orphan_taken", 64'(src_q[2].size()), 64'(0));
    tick();
    check("t5_perr_end", 64'(proto_err), 64'(0));
    src_q[1].push_back(mk_beat(1, 5, 1, 3));
    src_q[3].push_back(mk_beat(3, 5, 1, 3));
    refresh();
    tick();
    check("t5_multi_pulse", 64'(proto_err), 64'(1));
    tick();
    check("t5_multi_end", 64'(proto_err), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));

    // Five single-beat messages on port 0 saturate a 2-bit counter at 3.
    do_reset();
    for (int k = 0; k < 5; k++) push_msg(0, 1, k);
    refresh();
    wait_out(5, 40);
    tick();
    check("t6_msg_cnt_sat", 64'(msg_cnt[0]), 64'(3));
    if (outcyc.size() >= 2) check("t6_single_spacing", 64'(outcyc[1] - outcyc[0]), 64'(2));

    // Reset mid-message: remaining beats become orphans.
    do_reset();
    push_msg(1, 3, 7);
    refresh();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("t7_rst_ready", 64'(tb_ready[1]), 64'(0));
    check("t7_rst_grant", 64'(grant_oh), 64'(0));
    check("t7_rst_out_valid", 64'(msg_out_if.valid), 64'(0));
    tick();
    rst_n = 1'b1;
    p0 = perr_cnt;
    #1;
    check("t7_orphan_ready", 64'(tb_ready[1]), 64'(1));
    tick();
    tick();
    tick();
    check("t7_out_count", 64'(outq.size()), 64'(1));
    check("t7_src_empty", 64'(src_q[1].size()), 64'(0));
    check("t7_perr_cycles", 64'(perr_cnt - p0), 64'(2));
    check("t7_msg_cnt", 64'(msg_cnt[1]), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/msg_rr_arbiter.md
MSG_RR_ARBITER -- requirements
Module: msg_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of input message streams (2..16).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of each per-port counter.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port msg_in[NUM_PORTS], avalon_st_if.slave array: requester streams (data, empty, sop, eop, valid, ready).
REQ-006 The block SHALL have port msg_out, avalon_st_if.master: the single shared output stream.
REQ-007 The block SHALL have port port_en, input, NUM_PORTS bits: 1 = port arbitrated, 0 = port's messages drained and dropped.
REQ-008 The block SHALL have port grant_oh, output, NUM_PORTS bits: one-hot owner of msg_out, all-zero when idle.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a message is locked onto msg_out.
REQ-010 The block SHALL have port msg_cnt[NUM_PORTS], output, CNT_W bits each: messages forwarded per port.
REQ-011 The block SHALL have port drop_cnt[NUM_PORTS], output, CNT_W bits each: messages drained per port.
REQ-012 The block SHALL have port proto_err, output, 1 bit: one-cycle pulse on a discarded orphan beat.

Function
REQ-013 Beat accepted on port p SHALL mean msg_in[p].valid & msg_in[p].ready in the same cycle; on msg_out it SHALL mean msg_out.valid & msg_out.ready.
REQ-014 The FSM SHALL have states IDLE and LOCKED; busy SHALL be 1 exactly in LOCKED.
REQ-015 In IDLE, a port SHALL request when valid & sop & port_en & not draining.
REQ-016 In IDLE, the winner SHALL be the first requesting port in circular order starting at last_grant+1 mod NUM_PORTS.
REQ-017 On a win, the FSM SHALL register grant_oh and go to LOCKED on the next edge; msg_out.valid SHALL be 0 in that IDLE cycle.
REQ-018 Latency: a message's first beat SHALL appear on msg_out one cycle after its sop is presented in IDLE.
REQ-019 In LOCKED with owner g: msg_out data/empty/sop/eop/valid SHALL equal msg_in[g]; msg_in[g].ready SHALL equal msg_out.ready combinationally.
REQ-020 Once locked, the grant SHALL be held until the eop beat is accepted on msg_out, regardless of port_en or other requests.
REQ-021 On accepted eop in LOCKED: FSM -> IDLE; last_grant <= g; msg_cnt[g] += 1; grant_oh <= 0.
REQ-022 A single-beat message (sop & eop) SHALL lock for exactly one accepted beat; the next arbitration SHALL be possible in the following cycle.
REQ-023 A non-owner port with port_en=1 and valid & sop SHALL see ready=0 until granted.
REQ-024 A non-owner port presenting valid & sop with port_en=0 SHALL enter draining: ready=1 until its eop beat is accepted.
REQ-025 A draining port's beats SHALL never reach msg_out.
REQ-026 drop_cnt[p] SHALL increment once per drained eop beat; sop & eop counts as one message.
REQ-027 A draining port SHALL stay draining to eop even if port_en rises mid-message; port_en SHALL be sampled only at sop.
REQ-028 An orphan beat (valid & !sop on a port that is neither owner nor draining) SHALL be accepted (ready=1), discarded, and pulse proto_err the next cycle.
REQ-029 If several orphan beats occur in one cycle, proto_err SHALL still pulse once.
REQ-030 msg_cnt and drop_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-031 msg_out.valid SHALL be 0 whenever grant_oh is all-zero.
REQ-032 msg_out stall (ready=0) SHALL be backpressured to the owner only; no beat SHALL be lost or duplicated.

Reset
REQ-033 While rst_n=0: FSM=IDLE, grant_oh=0, busy=0, msg_out.valid=0, all counters=0, proto_err=0, no draining flags, last_grant=NUM_PORTS-1 (port 0 wins first).
REQ-034 Reset mid-message SHALL abandon the message; after release, that port's remaining beats SHALL be treated as orphans.

Verification
REQ-035 Ports 0..3 each present one 3-beat message simultaneously, msg_out.ready=1 -> grants 0,1,2,3 in order; 12 beats out, no interleave; msg_cnt=1 each.
REQ-036 Port 1 sends back-to-back messages while port 2 also waits -> order 1,2,1,2; no port is granted twice while another is waiting.
REQ-037 port_en[3]=0; port 3 sends a 4-beat message, port_en[3] rises after beat 2 -> all 4 beats drained, drop_cnt[3]=1, nothing on msg_out.
REQ-038 Owner port 0 mid-message, msg_out.ready toggles 1,0,0,1 -> msg_in[0].ready mirrors it; the beat sequence out equals the input sequence exactly.
REQ-039 Port 2 valid with sop=0 in IDLE -> accepted, proto_err high for one cycle, msg_out.valid stays 0.
REQ-040 CNT_W=2, five single-beat messages from port 0 -> msg_cnt[0] stops at 3.
